// File: rtl/instr_encoder.sv
// Purpose: packs MIPS instruction classes and fields into 32-bit words and writes them to consecutive imem addresses.
// Latency: one cycle from accepted transfer to mem_we/mem_addr/mem_wdata; one word per cycle sustained.
// Backpressure: in_ready drops on start, or once written plus pending words reach DEPTH; it recovers on start or reset.
module instr_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              bad_op
);

    // Instruction class codes on op_sel
    localparam logic [4:0] OP_RTYPE = 5'd0;
    localparam logic [4:0] OP_LW    = 5'd1;
    localparam logic [4:0] OP_SW    = 5'd2;
    localparam logic [4:0] OP_BEQ   = 5'd3;
    localparam logic [4:0] OP_BNE   = 5'd4;
    localparam logic [4:0] OP_ADDI  = 5'd5;
    localparam logic [4:0] OP_ANDI  = 5'd6;
    localparam logic [4:0] OP_ORI   = 5'd7;
    localparam logic [4:0] OP_SLTI  = 5'd8;
    localparam logic [4:0] OP_J     = 5'd9;
    localparam logic [4:0] OP_JAL   = 5'd10;
    localparam logic [4:0] OP_LUI   = 5'd11;
    localparam logic [4:0] OP_LB    = 5'd12;
    localparam logic [4:0] OP_LH    = 5'd13;
    localparam logic [4:0] OP_SB    = 5'd14;
    localparam logic [4:0] OP_SH    = 5'd15;
    localparam logic [4:0] OP_BGEZ  = 5'd16;

    // Word layout families
    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_t;

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [5:0]        w_opcode;
    fmt_t              w_fmt;
    logic              w_supported;
    logic [4:0]        w_rs_eff;
    logic [4:0]        w_rt_eff;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_committed;
    logic [ADDR_W:0]   w_count_nxt;
    logic              w_xfer;

    logic              r_we;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_bad;

    // Map instruction class to opcode and word format; flag unsupported classes
    always_comb begin
        w_opcode    = 6'b000000;
        w_fmt       = FMT_I;
        w_supported = 1'b1;
        case (op_sel)
            OP_RTYPE: begin w_opcode = 6'b000000; w_fmt = FMT_R; end
            OP_LW:    w_opcode = 6'b100011;
            OP_SW:    w_opcode = 6'b101011;
            OP_BEQ:   w_opcode = 6'b000100;
            OP_BNE:   w_opcode = 6'b000101;
            OP_ADDI:  w_opcode = 6'b001000;
            OP_ANDI:  w_opcode = 6'b001100;
            OP_ORI:   w_opcode = 6'b001101;
            OP_SLTI:  w_opcode = 6'b001010;
            OP_J:     begin w_opcode = 6'b000010; w_fmt = FMT_J; end
            OP_JAL:   begin w_opcode = 6'b000011; w_fmt = FMT_J; end
            OP_LUI:   w_opcode = 6'b001111;
            OP_LB:    w_opcode = 6'b100000;
            OP_LH:    w_opcode = 6'b100001;
            OP_SB:    w_opcode = 6'b101000;
            OP_SH:    w_opcode = 6'b101001;
            OP_BGEZ:  w_opcode = 6'b000001;
            default:  w_supported = 1'b0;
        endcase
    end

    // lui has no source register and bgez carries its sub-opcode in the rt slot
    assign w_rs_eff = (op_sel == OP_LUI)  ? 5'd0 : rs;
    assign w_rt_eff = (op_sel == OP_BGEZ) ? 5'd1 : rt;

    // Assemble the 32-bit instruction word for the selected format
    always_comb begin
        w_word = 32'h0000_0000;
        case (w_fmt)
            FMT_R:   w_word = {6'b000000, rs, rt, rd, shamt, funct};
            FMT_J:   w_word = {w_opcode, target};
            default: w_word = {w_opcode, w_rs_eff, w_rt_eff, imm};
        endcase
    end

    // A write in flight already owns a slot, so it is counted before accepting more
    assign w_committed = r_count + {{ADDR_W{1'b0}}, r_we};
    assign w_count_nxt = r_count + {{ADDR_W{1'b0}}, 1'b1};
    assign in_ready    = !start && (w_committed < L_DEPTH);
    assign w_xfer      = in_valid && in_ready;

    // Write-port stage: one-cycle strobe per accepted supported word; data held between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_wdata <= 32'h0000_0000;
        end else begin
            r_we <= 1'b0;
            if (w_xfer && w_supported) begin
                r_we    <= 1'b1;
                r_wdata <= w_word;
            end
        end
    end

    // Address, fill count, full and sticky bad-op tracking; start clears after any in-flight write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_bad   <= 1'b0;
        end else if (start) begin
            r_addr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            if (r_we) begin
                r_addr  <= r_addr + 1'b1;
                r_count <= w_count_nxt;
                r_full  <= (w_count_nxt == L_DEPTH);
            end
            if (w_xfer && !w_supported) begin
                r_bad <= 1'b1;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign full      = r_full;
    assign bad_op    = r_bad;

endmodule

// File: tb/tb_instr_encoder.sv
// Purpose: self-checking bench for instr_encoder (DEPTH=4) using an expected-write queue.
// Latency: expects each accepted supported word on mem_we one cycle after its transfer edge.
// Backpressure: driver waits on in_ready with a bounded cycle budget per transfer.
module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op_sel, rs, rt, rd, shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              bad_op;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_wr  = 0;
    int   exp_addr = 0;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .bad_op(bad_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Pop and compare every write strobe against the scoreboard
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            n_wr++;
            if (q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", {{(32-ADDR_W){1'b0}}, mem_addr}, e.addr);
                chk("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction and hold it until accepted; called just after a rising edge
    task automatic send(input logic [4:0] op, input logic [4:0] rs_v, input logic [4:0] rt_v,
                        input logic [4:0] rd_v, input logic [4:0] sh_v, input logic [5:0] fn_v,
                        input logic [15:0] im_v, input logic [25:0] tg_v,
                        input logic [31:0] wexp, input bit do_wr);
        bit ok;
        ok = 1'b0;
        op_sel = op; rs = rs_v; rt = rt_v; rd = rd_v; shamt = sh_v;
        funct = fn_v; imm = im_v; target = tg_v;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (do_wr) begin
                    q.push_back('{addr: exp_addr, data: wexp});
                    exp_addr++;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        #1;
        chk("start_blocks_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_addr = 0;
        chk("start_count", {29'd0, count}, 32'd0);
        chk("start_full", {31'd0, full}, 32'd0);
        chk("start_bad_op", {31'd0, bad_op}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        op_sel = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; target = '0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {30'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_bad_op", {31'd0, bad_op}, 32'd0);
        @(posedge clk);
        #1;

        // add $3,$1,$2: presented exactly one cycle after the transfer edge, single-cycle pulse
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 32'h0022_1820, 1'b1);
        chk("add_latency_we", {31'd0, mem_we}, 32'd1);
        chk("add_latency_data", mem_wdata, 32'h0022_1820);
        tick(1);
        chk("add_pulse_we", {31'd0, mem_we}, 32'd0);
        chk("add_wdata_hold", mem_wdata, 32'h0022_1820);
        chk("add_count", {29'd0, count}, 32'd1);
        do_start();

        // lw / addi / j back to back
        wr0 = n_wr;
        send(5'd1, 5'd29, 5'd9, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 32'h8FA9_0004, 1'b1);
        send(5'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 32'h2008_0005, 1'b1);
        send(5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h010_0000, 32'h0810_0000, 1'b1);
        chk("stream_last_we", {31'd0, mem_we}, 32'd1);
        chk("stream_last_addr", {30'd0, mem_addr}, 32'd2);
        tick(1);
        chk("stream_count", {29'd0, count}, 32'd3);
        chk("stream_writes", n_wr - wr0, 32'd3);
        do_start();

        // forced rs on lui, forced rt on bgez
        send(5'd11, 5'd7, 5'd5, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 32'h3C05_1234, 1'b1);
        send(5'd16, 5'd4, 5'd9, 5'd0, 5'd0, 6'h0, 16'hFFFE, 26'h0, 32'h0481_FFFE, 1'b1);
        tick(1);
        chk("forced_count", {29'd0, count}, 32'd2);
        do_start();

        // unsupported op between two valid ones
        wr0 = n_wr;
        send(5'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 32'h2008_0005, 1'b1);
        send(5'd20, 5'd1, 5'd2, 5'd3, 5'd4, 6'h3F, 16'hFFFF, 26'h3FF_FFFF, 32'h0, 1'b0);
        chk("badop_no_we", {31'd0, mem_we}, 32'd0);
        send(5'd7, 5'd0, 5'd3, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0, 32'h3403_00FF, 1'b1);
        tick(2);
        chk("badop_set", {31'd0, bad_op}, 32'd1);
        chk("badop_count", {29'd0, count}, 32'd2);
        chk("badop_writes", n_wr - wr0, 32'd2);
        tick(2);
        chk("badop_sticky", {31'd0, bad_op}, 32'd1);
        do_start();

        // fill to DEPTH with in_valid held for 6 cycles
        wr0 = n_wr;
        op_sel = 5'd5; rs = 5'd0; rt = 5'd8; imm = 16'h0005;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{addr: exp_addr, data: 32'h2008_0005});
                exp_addr++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        tick(2);
        chk("fill_writes", n_wr - wr0, 32'd4);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_count", {29'd0, count}, 32'd4);
        do_start();
        send(5'd7, 5'd0, 5'd3, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0, 32'h3403_00FF, 1'b1);
        chk("refill_addr", {30'd0, mem_addr}, 32'd0);

        // start while that write is in flight: it lands at 0, then state clears
        do_start();
        send(5'd2, 5'd29, 5'd31, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0, 32'hAFBF_0008, 1'b1);
        chk("after_pending_start_addr", {30'd0, mem_addr}, 32'd0);
        tick(1);

        // start together with in_valid: no transfer
        wr0 = n_wr;
        op_sel = 5'd5; rs = 5'd0; rt = 5'd8; imm = 16'h0005;
        in_valid = 1'b1;
        start = 1'b1;
        #1;
        chk("start_valid_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b0;
        exp_addr = 0;
        chk("start_valid_no_we", {31'd0, mem_we}, 32'd0);
        tick(1);
        chk("start_valid_writes", n_wr - wr0, 32'd0);

        // async reset mid-stream: pending word is dropped
        send(5'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 32'h2008_0005, 1'b1);
        send(5'd6, 5'd2, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0F0F, 26'h0, 32'h3044_0F0F, 1'b1);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("arst_count", {29'd0, count}, 32'd0);
        chk("arst_mem_addr", {30'd0, mem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr = 0;
        @(posedge clk);
        #1;
        send(5'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0040, 32'h0C00_0040, 1'b1);
        chk("arst_first_addr", {30'd0, mem_addr}, 32'd0);
        tick(3);
        chk("queue_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
